// File: rtl/fakeram_dp_fifo_ctrl_pkg.sv
// Shared constants for the dual-port fakeram FIFO controller.
//   AW_DEF / DW_DEF : default RAM address / data widths (256 x 64 macro)
//   OUTBUF_DEPTH    : entries in the prefetch buffer in front of pop
//   *_DEFAULT       : macro tie-off values, constant in every cycle
package fakeram_dp_pkg;

    localparam int AW_DEF       = 8;
    localparam int DW_DEF       = 64;
    localparam int OUTBUF_DEPTH = 2;

    localparam logic [2:0] EMA_DEFAULT   = 3'b010;
    localparam logic       STOV_DEFAULT  = 1'b0;
    localparam logic       EMASA_DEFAULT = 1'b0;
    localparam logic       RET1N_DEFAULT = 1'b1;

endpackage

// File: rtl/fakeram_dp_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for the fakeram FIFO controller.
//   push_valid/push_ready/push_data : write side
//   pop_valid/pop_ready/pop_data    : read side
// master = the client (producer + consumer), slave = the controller.
interface fakeram_dp_fifo_ctrl_if
    import fakeram_dp_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/fakeram_dp_outbuf.sv
// Small synchronous FIFO holding words already read out of the RAM.
//   clk, rst   : clock, synchronous active-high reset
//   push/data  : capture a word at the tail
//   pop        : drop the head word
//   count      : words held (0..OUTBUF_DEPTH)
//   head       : head word, valid while count != 0
// Push and pop in the same cycle are both honoured. The caller never
// pushes into a full buffer unless it pops in the same cycle.
module fakeram_dp_outbuf
    import fakeram_dp_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push,
    input  logic [DW-1:0]                         push_data,
    input  logic                                  pop,
    output logic [$clog2(OUTBUF_DEPTH+1)-1:0]     count,
    output logic [DW-1:0]                         head
);
    localparam int IW = $clog2(OUTBUF_DEPTH);
    localparam int CW = $clog2(OUTBUF_DEPTH + 1);

    logic [DW-1:0] mem [OUTBUF_DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    // Depth is a power of two, so the indices wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) wr_idx <= wr_idx + IW'(1);
            if (pop)  rd_idx <= rd_idx + IW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; count gates every use of it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_data;
    end

    assign head = mem[rd_idx];

endmodule

// File: rtl/fakeram_dp_fifo_ctrl.sv
// Ready/valid FIFO built on a 2**AW x DW dual-port fakeram macro.
//   CLK, RST          : clock, synchronous active-high reset
//   bus (slave)       : push/pop handshake
//   occupancy         : words held (RAM + in-flight read + output buffer)
//   CENA/AA/QA        : macro port A, read only
//   CENB/AB/DB        : macro port B, write only
//   STOV..EMAB, RET1N : constant macro tie-offs
// The macro drives port-B data onto QA whenever CENB is low, so writes
// are held off in every read-return cycle (rd_pending).
module fakeram_dp_fifo_ctrl
    import fakeram_dp_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    fakeram_dp_fifo_ctrl_if.slave        bus,
    output logic [AW+1:0]                occupancy,
    output logic                         CENA,
    output logic [AW-1:0]                AA,
    input  logic [DW-1:0]                QA,
    output logic                         CENB,
    output logic [AW-1:0]                AB,
    output logic [DW-1:0]                DB,
    output logic                         STOV,
    output logic                         EMASA,
    output logic                         RET1N,
    output logic [2:0]                   EMAA,
    output logic [2:0]                   EMAB
);
    localparam int          CW    = $clog2(OUTBUF_DEPTH + 1);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   mem_count;
    logic          rd_pending;
    logic [CW-1:0] out_count;
    logic [CW:0]   out_after;
    logic          push_fire;
    logic          pop_fire;
    logic          rd_issue;

    // Extra pointer bit lets mem_count tell full (DEPTH) from empty (0).
    assign mem_count = wr_ptr - rd_ptr;

    assign bus.push_ready = !RST && (mem_count != DEPTH) && !rd_pending;
    assign push_fire      = bus.push_valid && bus.push_ready;
    assign pop_fire       = bus.pop_valid && bus.pop_ready;

    // Buffer slots still claimed after this cycle's pop; a read is only
    // issued if its data is guaranteed a slot when it returns.
    assign out_after = (CW+1)'(out_count) + (CW+1)'(rd_pending) - (CW+1)'(pop_fire);
    assign rd_issue  = !RST && (mem_count != '0) && (out_after < (CW+1)'(OUTBUF_DEPTH));

    assign CENB = !push_fire;
    assign AB   = wr_ptr[AW-1:0];
    assign DB   = bus.push_data;
    assign CENA = !rd_issue;
    assign AA   = rd_ptr[AW-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + (AW+1)'(push_fire);
            rd_ptr     <= rd_ptr + (AW+1)'(rd_issue);
            rd_pending <= rd_issue;
        end
    end

    // The buffer's own reset wins over a capture, so a read in flight
    // across reset is dropped.
    fakeram_dp_outbuf #(
        .DW        (DW)
    ) u_outbuf (
        .clk       (CLK),
        .rst       (RST),
        .push      (rd_pending),
        .push_data (QA),
        .pop       (pop_fire),
        .count     (out_count),
        .head      (bus.pop_data)
    );

    assign bus.pop_valid = (out_count != '0);

    assign occupancy = (AW+2)'(mem_count) + (AW+2)'(rd_pending) + (AW+2)'(out_count);

    assign STOV  = STOV_DEFAULT;
    assign EMASA = EMASA_DEFAULT;
    assign RET1N = RET1N_DEFAULT;
    assign EMAA  = EMA_DEFAULT;
    assign EMAB  = EMA_DEFAULT;

endmodule

// File: tb/tb_fakeram_dp_fifo_ctrl.sv
// Bench for fakeram_dp_fifo_ctrl: behavioural macro model, scoreboard
// queue of accepted words, and a negedge monitor comparing every pop.
module tb_fakeram_dp_fifo_ctrl;
    localparam int AW  = 8;
    localparam int DW  = 64;
    localparam int CAP = 258;

    logic          CLK;
    logic          RST;
    logic [AW+1:0] occupancy;
    logic          CENA, CENB;
    logic [AW-1:0] AA, AB;
    logic [DW-1:0] QA, DB;
    logic          STOV, EMASA, RET1N;
    logic [2:0]    EMAA, EMAB;

    fakeram_dp_fifo_ctrl_if #(.DW(DW)) bus ();

    fakeram_dp_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .occupancy (occupancy),
        .CENA      (CENA),
        .AA        (AA),
        .QA        (QA),
        .CENB      (CENB),
        .AB        (AB),
        .DB        (DB),
        .STOV      (STOV),
        .EMASA     (EMASA),
        .RET1N     (RET1N),
        .EMAA      (EMAA),
        .EMAB      (EMAB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Macro model, including the QA-follows-DB quirk while CENB is low.
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] qa_q;
    always @(posedge CLK) begin
        if (!CENA) qa_q <= ram[AA];
        if (!CENB) ram[AB] <= DB;
    end
    assign QA = !CENB ? DB : qa_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted word, in order, until it is popped.
    logic [DW-1:0] sb[$];
    logic [AW-1:0] wr_cnt = '0;
    logic [AW-1:0] rd_cnt = '0;
    logic          prev_cena = 1'b1;

    initial forever begin
        @(negedge CLK);
        chk("tieoff", 64'({STOV, EMASA, RET1N, EMAA, EMAB}), 64'({1'b0, 1'b0, 1'b1, 3'b010, 3'b010}));
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        if (RST) begin
            chk("rst_push_ready", 64'(bus.push_ready), 64'(0));
            chk("rst_cena", 64'(CENA), 64'(1));
            chk("rst_cenb", 64'(CENB), 64'(1));
        end
        if (!prev_cena) chk("write_in_return", 64'(CENB), 64'(1));
        if (sb.size() >= CAP) chk("full_ready", 64'(bus.push_ready), 64'(0));
        chk("cenb_strobe", 64'(CENB), 64'(!(bus.push_valid && bus.push_ready)));
        if (bus.pop_valid && bus.pop_ready) begin
            if (sb.size() == 0) chk("pop_empty_model", 64'(1), 64'(0));
            else                chk("pop_data", bus.pop_data, sb.pop_front());
        end
        if (!CENB) begin
            chk("ab", 64'(AB), 64'(wr_cnt));
            chk("db", DB, bus.push_data);
            wr_cnt++;
            sb.push_back(bus.push_data);
        end
        if (!CENA) begin
            chk("aa", 64'(AA), 64'(rd_cnt));
            rd_cnt++;
        end
        if (RST) begin
            sb.delete();
            wr_cnt = '0;
            rd_cnt = '0;
        end
        prev_cena = CENA;
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    int acc;
    int n;

    initial begin
        RST            = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_data  = '0;
        bus.pop_ready  = 1'b0;

        // Reset held three cycles with a push offered.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("reset_pop_valid", 64'(bus.pop_valid), 64'(0));
            chk("reset_occupancy", 64'(occupancy), 64'(0));
        end
        cyc();
        RST = 1'b0;
        bus.push_valid = 1'b0;

        // Single word, latency T -> T+3.
        cyc();
        bus.push_valid = 1'b1;
        bus.push_data  = 64'hDEAD_BEEF_0123_4567;
        @(negedge CLK);
        chk("single_push_ready", 64'(bus.push_ready), 64'(1));
        chk("single_cenb", 64'(CENB), 64'(0));
        chk("single_ab", 64'(AB), 64'(0));
        cyc();
        bus.push_valid = 1'b0;
        @(negedge CLK);
        chk("single_cena", 64'(CENA), 64'(0));
        chk("single_aa", 64'(AA), 64'(0));
        chk("single_t1_valid", 64'(bus.pop_valid), 64'(0));
        @(negedge CLK);
        chk("single_t2_valid", 64'(bus.pop_valid), 64'(0));
        @(negedge CLK);
        chk("single_t3_valid", 64'(bus.pop_valid), 64'(1));
        chk("single_t3_data", bus.pop_data, 64'hDEAD_BEEF_0123_4567);
        cyc();
        bus.pop_ready = 1'b1;
        cyc();
        bus.pop_ready = 1'b0;
        repeat (3) cyc();

        // Fill with no pops: capacity is 258.
        acc = 0;
        bus.push_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            bus.push_data = 64'(acc);
            @(negedge CLK);
            if (bus.push_valid && bus.push_ready) acc++;
            cyc();
        end
        @(negedge CLK);
        chk("fill_accepted", 64'(acc), 64'(CAP));
        chk("fill_push_ready", 64'(bus.push_ready), 64'(0));
        chk("fill_occupancy", 64'(occupancy), 64'(CAP));
        cyc();
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b1;
        n = 0;
        for (int c = 0; c < 1000 && n < CAP; c++) begin
            @(negedge CLK);
            if (bus.pop_valid) begin
                chk("drain_order", bus.pop_data, 64'(n));
                n++;
            end
        end
        chk("drain_count", 64'(n), 64'(CAP));
        cyc();
        bus.pop_ready = 1'b0;
        @(negedge CLK);
        chk("drain_occupancy", 64'(occupancy), 64'(0));

        // Push and pop held together; runs past three pointer wraps.
        cyc();
        acc = 0;
        bus.push_valid = 1'b1;
        bus.pop_ready  = 1'b1;
        for (int c = 0; c < 4000 && acc < 800; c++) begin
            bus.push_data = 64'h1000 + 64'(acc);
            @(negedge CLK);
            if (bus.push_valid && bus.push_ready) acc++;
            cyc();
        end
        chk("collision_words", 64'(acc >= 800), 64'(1));

        // Random push/pop mix.
        for (int c = 0; c < 1500; c++) begin
            bus.push_valid = ($urandom_range(0, 3) != 0);
            bus.push_data  = {$urandom, $urandom};
            bus.pop_ready  = ($urandom_range(0, 2) == 0);
            cyc();
        end
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b1;
        for (int c = 0; c < 1000 && occupancy != 0; c++) cyc();
        @(negedge CLK);
        chk("random_drain_occ", 64'(occupancy), 64'(0));
        chk("random_drain_model", 64'(sb.size()), 64'(0));

        // Reset mid-stream with 100 words held and a read in flight.
        cyc();
        bus.pop_ready  = 1'b0;
        bus.push_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 500 && acc < 101; c++) begin
            bus.push_data = 64'h2000 + 64'(acc);
            @(negedge CLK);
            if (bus.push_valid && bus.push_ready) acc++;
            cyc();
        end
        bus.push_valid = 1'b0;
        repeat (6) cyc();
        @(negedge CLK);
        chk("mid_occupancy", 64'(occupancy), 64'(101));
        cyc();
        bus.pop_ready = 1'b1;
        @(negedge CLK);
        chk("mid_read_issue", 64'(CENA), 64'(0));
        cyc();
        bus.pop_ready  = 1'b0;
        bus.push_valid = 1'b1;
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_pre_rst_occ", 64'(occupancy), 64'(100));
        cyc();
        RST = 1'b0;
        bus.push_data = 64'h5;
        @(negedge CLK);
        chk("post_rst_occ", 64'(occupancy), 64'(0));
        chk("post_rst_pop_valid", 64'(bus.pop_valid), 64'(0));
        chk("post_rst_push_ready", 64'(bus.push_ready), 64'(1));
        cyc();
        bus.push_valid = 1'b0;
        @(negedge CLK);
        chk("post_rst_cena", 64'(CENA), 64'(0));
        @(negedge CLK);
        chk("post_rst_t2_valid", 64'(bus.pop_valid), 64'(0));
        @(negedge CLK);
        chk("post_rst_t3_valid", 64'(bus.pop_valid), 64'(1));
        chk("post_rst_t3_data", bus.pop_data, 64'h5);
        cyc();
        bus.pop_ready = 1'b1;
        cyc();
        bus.pop_ready = 1'b0;
        repeat (3) cyc();
        @(negedge CLK);
        chk("final_occupancy", 64'(occupancy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
